// File: rtl/posit_dot_stream.sv
// Multi-lane streaming posit8 (es=0) dot-product engine with valid/ready in and out.
// Per lane: registered multiply stage, then registered accumulate stage; results held until m_ready.
package posit8_pkg;
  typedef struct packed {
    logic             s;
    logic signed [5:0] k;
    logic [5:0]       sig;
  } dec_t;

  // Sign, regime scale and hidden-bit significand of a non-zero, non-NaR posit.
  function automatic dec_t decode(input logic [7:0] p);
    dec_t d;
    logic [6:0] ab;
    logic [6:0] sh;
    logic       r0;
    logic       run;
    logic [3:0] m;
    ab  = p[7] ? 7'(~p + 8'd1) : p[6:0];
    r0  = ab[6];
    run = 1'b1;
    m   = 4'd0;
    for (int i = 6; i >= 0; i--) begin
      if (run && (ab[i] == r0)) m = m + 4'd1;
      else run = 1'b0;
    end
    sh    = ab << (m + 4'd1);
    d.s   = p[7];
    d.k   = r0 ? $signed({2'b00, m}) - 6'sd1 : -$signed({2'b00, m});
    d.sig = {1'b1, sh[6:2]};
    return d;
  endfunction

  // Round-to-nearest-even on the regime+fraction bit string; saturates to minpos/maxpos.
  function automatic logic [7:0] encode(input logic sgn, input logic signed [5:0] k,
                                        input logic [11:0] frac, input logic stk);
    logic [19:0] v;
    logic [3:0]  rlen;
    logic        rnd;
    logic [7:0]  mag;
    v    = '0;
    rlen = '0;
    rnd  = 1'b0;
    if (k >= 6'sd6) mag = 8'h7F;
    else if (k <= -6'sd7) mag = 8'h01;
    else begin
      if (k >= 6'sd0) begin
        rlen = 4'(k + 6'sd2);
        v    = ~(20'hFFFFF >> 5'(k + 6'sd1));
      end else begin
        rlen = 4'(6'sd1 - k);
        v    = 20'd1 << 5'(6'sd19 + k);
      end
      v   = v | ({frac, 8'd0} >> rlen);
      rnd = v[12] & (v[13] | stk | (|v[11:0]));
      mag = {1'b0, v[19:13]} + {7'd0, rnd};
    end
    return sgn ? (~mag + 8'd1) : mag;
  endfunction
endpackage

module posit_mult_8bit import posit8_pkg::*; (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] p
);
  dec_t              da, db;
  logic [11:0]       prod;
  logic [11:0]       frac;
  logic signed [5:0] k;

  always_comb begin
    da   = decode(a);
    db   = decode(b);
    prod = da.sig * db.sig;
    k    = da.k + db.k;
    frac = {prod[9:0], 2'b00};
    if (prod[11]) begin
      k    = k + 6'sd1;
      frac = {prod[10:0], 1'b0};
    end
    if (a == 8'h80 || b == 8'h80) p = 8'h80;
    else if (a == 8'h00 || b == 8'h00) p = 8'h00;
    else p = encode(da.s ^ db.s, k, frac, 1'b0);
  end
endmodule

module posit_adder_8bit import posit8_pkg::*; (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] s
);
  dec_t              da, db, bg, sm;
  logic [4:0]        d;
  logic [28:0]       ext;
  logic [16:0]       bv, sv, norm;
  logic [17:0]       sum;
  logic [4:0]        p;
  logic signed [5:0] kr;

  always_comb begin
    da = decode(a);
    db = decode(b);
    if (($signed(db.k) > $signed(da.k)) || (db.k == da.k && db.sig > da.sig)) begin
      bg = db;
      sm = da;
    end else begin
      bg = da;
      sm = db;
    end
    d   = 5'(bg.k - sm.k);
    // Smaller operand aligned with its shifted-out bits jammed into a sticky LSB.
    ext = {sm.sig, 23'd0} >> d;
    bv  = {bg.sig, 11'd0};
    sv  = {ext[28:13], |ext[12:0]};
    sum = (bg.s == sm.s) ? ({1'b0, bv} + {1'b0, sv}) : ({1'b0, bv} - {1'b0, sv});
    p   = 5'd0;
    for (int i = 0; i < 18; i++) if (sum[i]) p = 5'(i);
    norm = 17'(sum << (5'd17 - p));
    kr   = bg.k + $signed({1'b0, p}) - 6'sd16;
    if (a == 8'h80 || b == 8'h80) s = 8'h80;
    else if (a == 8'h00) s = b;
    else if (b == 8'h00) s = a;
    else if (sum == 18'd0) s = 8'h00;
    else s = encode(bg.s, kr, norm[16:5], |norm[4:0]);
  end
endmodule

module posit_dot_stream #(
  parameter int LANES = 4,
  parameter int LEN_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [8*LANES-1:0] s_a,
  input  logic [8*LANES-1:0] s_b,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [8*LANES-1:0] m_data,
  output logic [LANES-1:0]   m_nar,
  output logic [LEN_W-1:0]   elem_cnt,
  output logic               busy
);
  typedef enum logic [1:0] {ST_ACC, ST_FLUSH, ST_OUT} state_t;

  state_t               state;
  logic [LEN_W-1:0]     len_q, len_sel;
  logic                 p1_valid, accept, last;
  logic [8*LANES-1:0]   prod, p1, acc, sum;

  assign accept  = s_valid & s_ready;
  // The first beat of a vector uses the live cfg_len; later beats use the latched copy.
  assign len_sel = (elem_cnt == '0) ? cfg_len : len_q;
  assign last    = (elem_cnt == len_sel - LEN_W'(1));
  assign busy    = !(state == ST_ACC && elem_cnt == '0);
  assign m_data  = acc;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    posit_mult_8bit  u_mul (.a(s_a[8*i +: 8]), .b(s_b[8*i +: 8]), .p(prod[8*i +: 8]));
    posit_adder_8bit u_add (.a(p1[8*i +: 8]),  .b(acc[8*i +: 8]), .s(sum[8*i +: 8]));
    assign m_nar[i] = (acc[8*i +: 8] == 8'h80);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_ACC;
      elem_cnt <= '0;
      len_q    <= '0;
      p1_valid <= 1'b0;
      p1       <= '0;
      acc      <= '0;
      s_ready  <= 1'b1;
      m_valid  <= 1'b0;
    end else if (clr) begin
      state    <= ST_ACC;
      elem_cnt <= '0;
      p1_valid <= 1'b0;
      acc      <= '0;
      s_ready  <= 1'b1;
      m_valid  <= 1'b0;
    end else begin
      if (p1_valid) acc <= sum;
      case (state)
        ST_ACC: begin
          p1_valid <= accept;
          if (accept) begin
            p1 <= prod;
            if (elem_cnt == '0) len_q <= cfg_len;
            if (last) begin
              elem_cnt <= '0;
              state    <= ST_FLUSH;
              s_ready  <= 1'b0;
            end else begin
              elem_cnt <= elem_cnt + LEN_W'(1);
            end
          end
        end
        ST_FLUSH: begin
          p1_valid <= 1'b0;
          state    <= ST_OUT;
          m_valid  <= 1'b1;
        end
        ST_OUT: begin
          if (m_ready) begin
            acc     <= '0;
            state   <= ST_ACC;
            m_valid <= 1'b0;
            s_ready <= 1'b1;
          end
        end
        default: begin
          state   <= ST_ACC;
          s_ready <= 1'b1;
          m_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule
